// File: rtl/sram_write_checker.sv
// sram_write_checker: snoops SRAM writes per region (count, MISR) and grades the run on stop.
module sram_write_checker #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int NUM_REGIONS = 2,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SIG_SEED = 32'hFFFFFFFF
) (
  input  logic Clock_50,
  input  logic Resetn,
  input  logic start_i,
  input  logic stop_i,
  input  logic sram_we_n_i,
  input  logic [ADDR_W-1:0] sram_addr_i,
  input  logic [DATA_W-1:0] sram_wdata_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
  input  logic [NUM_REGIONS*(ADDR_W+1)-1:0] region_size_i,
  input  logic [NUM_REGIONS*SIG_W-1:0] exp_sig_i,
  output logic armed_o,
  output logic done_o,
  output logic pass_o,
  output logic [NUM_REGIONS*(ADDR_W+1)-1:0] region_cnt_o,
  output logic [NUM_REGIONS*SIG_W-1:0] region_sig_o,
  output logic [15:0] oor_cnt_o,
  output logic [ADDR_W-1:0] first_oor_addr_o,
  output logic [3:0] err_flags_o
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt [NUM_REGIONS];
  logic [SIG_W-1:0] sig [NUM_REGIONS];
  logic [15:0] oor_cnt;
  logic [ADDR_W-1:0] first_oor;
  logic [3:0] err_flags, flags_c;
  logic [NUM_REGIONS-1:0] match, first_hit;
  logic [SIG_W-1:0] mix;
  logic clear, wr;
  function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] m);
    return {s[SIG_W-2:0], s[SIG_W-1]} ^ (s[SIG_W-1] ? SIG_POLY : '0) ^ m;
  endfunction
  assign clear = start_i && state != CHECK;
  assign wr = state == ARMED && !sram_we_n_i;
  assign mix = (SIG_W'(sram_wdata_i) << (SIG_W - DATA_W)) ^ SIG_W'(sram_addr_i);
  // offset compare avoids base+size overflowing the ADDR_W+1 range
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_reg
    logic [CW-1:0] base, size, off;
    assign base = CW'(region_base_i[g*ADDR_W +: ADDR_W]);
    assign size = region_size_i[g*CW +: CW];
    assign off = CW'(sram_addr_i) - base;
    assign match[g] = |size && CW'(sram_addr_i) >= base && off < size;
    assign region_cnt_o[g*CW +: CW] = cnt[g];
    assign region_sig_o[g*SIG_W +: SIG_W] = sig[g];
  end
  assign first_hit = match & (~match + NUM_REGIONS'(1));
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start_i ? ARMED : IDLE;
      ARMED: state_nxt = start_i ? ARMED : stop_i ? CHECK : ARMED;
      CHECK: state_nxt = DONE;
      DONE: state_nxt = start_i ? ARMED : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    armed_o = state == ARMED;
    done_o = state == DONE;
    pass_o = state == DONE && ~|err_flags;
  end
  always_comb begin
    flags_c = {3'b000, |oor_cnt};
    for (int i = 0; i < NUM_REGIONS; i++)
      if (|region_size_i[i*CW +: CW]) begin
        flags_c[3] = flags_c[3] | (sig[i] != exp_sig_i[i*SIG_W +: SIG_W]);
        flags_c[2] = flags_c[2] | (cnt[i] > region_size_i[i*CW +: CW]);
        flags_c[1] = flags_c[1] | (cnt[i] < region_size_i[i*CW +: CW]);
      end
  end
  always_ff @(posedge Clock_50 or negedge Resetn)
    if (!Resetn) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt[i] <= '0;
        sig[i] <= SIG_SEED;
      end
      oor_cnt <= '0;
      first_oor <= '0;
      err_flags <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt[i] <= '0;
        sig[i] <= SIG_SEED;
      end
      oor_cnt <= '0;
      first_oor <= '0;
      err_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (wr && first_hit[i]) begin
          cnt[i] <= &cnt[i] ? cnt[i] : cnt[i] + CW'(1);
          sig[i] <= misr(sig[i], mix);
        end
      if (wr && ~|match) begin
        oor_cnt <= &oor_cnt ? oor_cnt : oor_cnt + 16'd1;
        if (~|oor_cnt) first_oor <= sram_addr_i;
      end
      if (state == CHECK) err_flags <= flags_c;
    end
  assign oor_cnt_o = oor_cnt;
  assign first_oor_addr_o = first_oor;
  assign err_flags_o = err_flags;
endmodule

// File: tb/tb_sram_write_checker.sv
// tb_sram_write_checker: directed runs against hand-planned write images.
module tb_sram_write_checker;
  logic Clock_50 = 0, Resetn = 0, start_i = 0, stop_i = 0, sram_we_n_i = 1;
  logic [17:0] sram_addr_i = '0;
  logic [15:0] sram_wdata_i = '0;
  logic [35:0] region_base_i = '0;
  logic [37:0] region_size_i = '0;
  logic [63:0] exp_sig_i = '0;
  logic armed_o, done_o, pass_o;
  logic [37:0] region_cnt_o;
  logic [63:0] region_sig_o;
  logic [15:0] oor_cnt_o;
  logic [17:0] first_oor_addr_o;
  logic [3:0] err_flags_o;
  int checks = 0, failures = 0;
  logic [31:0] good_sig;
  sram_write_checker dut (
    .Clock_50(Clock_50), .Resetn(Resetn), .start_i(start_i), .stop_i(stop_i),
    .sram_we_n_i(sram_we_n_i), .sram_addr_i(sram_addr_i), .sram_wdata_i(sram_wdata_i),
    .region_base_i(region_base_i), .region_size_i(region_size_i), .exp_sig_i(exp_sig_i),
    .armed_o(armed_o), .done_o(done_o), .pass_o(pass_o), .region_cnt_o(region_cnt_o),
    .region_sig_o(region_sig_o), .oor_cnt_o(oor_cnt_o), .first_oor_addr_o(first_oor_addr_o),
    .err_flags_o(err_flags_o)
  );
  always #10 Clock_50 = ~Clock_50;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [17:0] a, input logic [15:0] d);
    logic [31:0] m;
    m = {d, 16'h0000} ^ {14'h0, a};
    return {s[30:0], s[31]} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ m;
  endfunction
  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    sram_we_n_i = 0; sram_addr_i = a; sram_wdata_i = d;
    @(negedge Clock_50);
    sram_we_n_i = 1;
  endtask
  task automatic start();
    start_i = 1;
    @(negedge Clock_50);
    start_i = 0;
  endtask
  task automatic finish_run(input string tag);
    stop_i = 1;
    @(negedge Clock_50);
    stop_i = 0;
    for (int k = 0; k < 4 && !done_o; k++) @(negedge Clock_50);
    check({tag, "_done"}, done_o, 1);
  endtask
  task automatic img(input logic [15:0] d1);
    wr(18'd146944, 16'h1111); wr(18'd146945, d1); wr(18'd146946, 16'h3333); wr(18'd146947, 16'h4444);
  endtask
  initial begin
    good_sig = 32'hFFFFFFFF;
    good_sig = misr(good_sig, 18'd146944, 16'h1111);
    good_sig = misr(good_sig, 18'd146945, 16'h2222);
    good_sig = misr(good_sig, 18'd146946, 16'h3333);
    good_sig = misr(good_sig, 18'd146947, 16'h4444);
    region_base_i = {18'd0, 18'd146944};
    region_size_i = {19'd0, 19'd4};
    exp_sig_i = {32'h0, good_sig};
    repeat (2) @(negedge Clock_50);
    check("rst_armed", armed_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_cnt", region_cnt_o, 0);
    check("rst_sig", region_sig_o, 64'hFFFFFFFF_FFFFFFFF);
    check("rst_oor", {oor_cnt_o, first_oor_addr_o, err_flags_o}, 0);
    Resetn = 1;
    @(negedge Clock_50);
    start();
    check("armed", armed_o, 1);
    wr(18'd146944, 16'h1111);
    check("latency_cnt0", region_cnt_o[18:0], 1);
    check("latency_sig0", region_sig_o[31:0], misr(32'hFFFFFFFF, 18'd146944, 16'h1111));
    wr(18'd146945, 16'h2222); wr(18'd146946, 16'h3333); wr(18'd146947, 16'h4444);
    check("not_done", done_o, 0);
    finish_run("good");
    check("good_pass", pass_o, 1);
    check("good_cnt0", region_cnt_o[18:0], 4);
    check("good_cnt1", region_cnt_o[37:19], 0);
    check("good_err", err_flags_o, 0);
    check("good_sig0", region_sig_o[31:0], good_sig);
    check("good_armed", armed_o, 0);
    start();
    img(16'h2222); wr(18'd100, 16'hABCD);
    finish_run("oor");
    check("oor_cnt", oor_cnt_o, 1);
    check("oor_first", first_oor_addr_o, 100);
    check("oor_err", err_flags_o, 4'b0001);
    check("oor_pass", pass_o, 0);
    start();
    check("restart_clear", {oor_cnt_o, first_oor_addr_o, err_flags_o, done_o}, 0);
    wr(18'd146944, 16'h1111); img(16'h2222);
    finish_run("ovr");
    check("ovr_cnt0", region_cnt_o[18:0], 5);
    check("ovr_flags", err_flags_o[2:1], 2'b10);
    start();
    wr(18'd146944, 16'h1111); wr(18'd146945, 16'h2222); wr(18'd146946, 16'h3333);
    finish_run("und");
    check("und_cnt0", region_cnt_o[18:0], 3);
    check("und_flags", err_flags_o[2:1], 2'b01);
    start();
    img(16'h2223);
    finish_run("sig");
    check("sig_err", err_flags_o, 4'b1000);
    check("sig_pass", pass_o, 0);
    region_base_i = {18'd1005, 18'd1000};
    region_size_i = {19'd15, 19'd10};
    start();
    wr(18'd1007, 16'h5555);
    check("ovl_cnt", region_cnt_o, {19'd0, 19'd1});
    sram_we_n_i = 0; sram_addr_i = 18'd1012; sram_wdata_i = 16'h6666; stop_i = 1;
    @(negedge Clock_50);
    sram_we_n_i = 1; stop_i = 0;
    check("stop_wr_cnt", region_cnt_o, {19'd1, 19'd1});
    for (int k = 0; k < 4 && !done_o; k++) @(negedge Clock_50);
    check("ovl_done", done_o, 1);
    start_i = 1; stop_i = 1;
    @(negedge Clock_50);
    check("ss_from_done", {armed_o, done_o}, 2'b10);
    @(negedge Clock_50);
    start_i = 0; stop_i = 0;
    check("ss_in_armed", armed_o, 1);
    region_base_i = {18'd0, 18'd146944};
    region_size_i = {19'd0, 19'd4};
    start();
    wr(18'd146944, 16'h1111); wr(18'd146945, 16'h2222); wr(18'd300, 16'h0001);
    Resetn = 0;
    #1;
    check("mid_rst_ctl", {armed_o, done_o, pass_o}, 0);
    check("mid_rst_cnt", {region_cnt_o, oor_cnt_o, first_oor_addr_o, err_flags_o}, 0);
    check("mid_rst_sig", region_sig_o, 64'hFFFFFFFF_FFFFFFFF);
    @(negedge Clock_50);
    Resetn = 1;
    @(negedge Clock_50);
    check("post_rst_idle", armed_o, 0);
    start();
    img(16'h2222);
    finish_run("rerun");
    check("rerun_pass", pass_o, 1);
    check("rerun_cnt0", region_cnt_o[18:0], 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
